// File: rtl/mips_clz_pipe_if.sv
// rtl/mips_clz_pipe_if.sv - handshake/operand bundle for the pipelined CLZ/CLO counter
//
// Signals (directions as seen by the counter, modport slave):
//   flush_i  in   kill all in-flight operations
//   valid_i  in   operand valid
//   ready_o  out  unit can accept operand
//   op_i     in   0 = CLZ, 1 = CLO
//   data_i   in   operand, leading bit is DATA_WIDTH-1
//   tag_i    in   opaque sideband returned with the result
//   valid_o  out  result valid
//   ready_i  in   consumer accepts result
//   res_o    out  count 0..DATA_WIDTH
//   zero_o   out  no terminating bit found (res_o == DATA_WIDTH)
//   tag_o    out  tag of the result
interface mips_clz_pipe_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_LOG2 = 5,
    parameter int TAG_WIDTH       = 4
);
    logic                       flush_i;
    logic                       valid_i;
    logic                       ready_o;
    logic                       op_i;
    logic [DATA_WIDTH-1:0]      data_i;
    logic [TAG_WIDTH-1:0]       tag_i;
    logic                       valid_o;
    logic                       ready_i;
    logic [DATA_WIDTH_LOG2:0]   res_o;
    logic                       zero_o;
    logic [TAG_WIDTH-1:0]       tag_o;

    modport slave (
        input  flush_i, valid_i, op_i, data_i, tag_i, ready_i,
        output ready_o, valid_o, res_o, zero_o, tag_o
    );

    modport master (
        output flush_i, valid_i, op_i, data_i, tag_i, ready_i,
        input  ready_o, valid_o, res_o, zero_o, tag_o
    );
endinterface

// File: rtl/mips_clz_pipe.sv
// rtl/mips_clz_pipe.sv - two-stage pipelined leading-zero/leading-one counter
//
// Ports:
//   clk_i    single clock
//   rst_n_i  asynchronous active-low reset
//   bus      mips_clz_pipe_if.slave (operand side valid/ready, result side valid/ready, flush)
//
// Stage 1 splits the (optionally inverted) operand into groups and registers a
// per-group all-zero flag and local leading-zero count. Stage 2 picks the first
// non-empty group and registers the final count.
module mips_clz_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_LOG2 = 5,
    parameter int GROUP_WIDTH     = 8,
    parameter int TAG_WIDTH       = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    mips_clz_pipe_if.slave    bus
);
    localparam int NUM_GROUPS = DATA_WIDTH / GROUP_WIDTH;
    localparam int LCW        = $clog2(GROUP_WIDTH);
    localparam int RW         = DATA_WIDTH_LOG2 + 1;

    // Leading zeros within one group; only meaningful when the group is non-zero.
    // Scanning upward lets the highest set bit win without a found flag.
    function automatic logic [LCW-1:0] grp_lz(input logic [GROUP_WIDTH-1:0] v);
        logic [LCW-1:0] c;
        c = '0;
        for (int i = 0; i < GROUP_WIDTH; i++) begin
            if (v[i]) c = LCW'(GROUP_WIDTH - 1 - i);
        end
        return c;
    endfunction

    // Pipeline state
    logic                           s1_valid;
    logic [NUM_GROUPS-1:0]          s1_az;
    logic [NUM_GROUPS-1:0][LCW-1:0] s1_lc;
    logic [TAG_WIDTH-1:0]           s1_tag;

    logic                           s2_valid;
    logic [RW-1:0]                  s2_res;
    logic                           s2_zero;
    logic [TAG_WIDTH-1:0]           s2_tag;

    // Handshake
    logic s1_free;
    logic accept;
    logic s2_load;

    // S1 can take a new operand if it is empty or its content moves to S2 this cycle.
    assign s1_free = !s1_valid || !s2_valid || bus.ready_i;
    assign bus.ready_o = s1_free && !bus.flush_i;
    assign accept  = bus.valid_i && bus.ready_o;
    assign s2_load = s1_valid && (!s2_valid || bus.ready_i);

    // Stage 1 combinational: CLO becomes CLZ of the inverted operand.
    logic [DATA_WIDTH-1:0]          x;
    logic [GROUP_WIDTH-1:0]         grp;
    logic [NUM_GROUPS-1:0]          az_c;
    logic [NUM_GROUPS-1:0][LCW-1:0] lc_c;

    always_comb begin
        x    = bus.op_i ? ~bus.data_i : bus.data_i;
        grp  = '0;
        az_c = '0;
        lc_c = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            // g = 0 is the most significant group
            grp     = x[DATA_WIDTH-1-g*GROUP_WIDTH -: GROUP_WIDTH];
            az_c[g] = (grp == '0);
            lc_c[g] = grp_lz(grp);
        end
    end

    // Stage 2 combinational: the lowest-index non-empty group decides the count.
    logic [RW-1:0] res_c;
    logic          zero_c;

    always_comb begin
        res_c  = RW'(DATA_WIDTH);
        zero_c = &s1_az;
        for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
            if (!s1_az[g]) res_c = RW'(g * GROUP_WIDTH) + RW'(s1_lc[g]);
        end
    end

    // Valid bits: flush wins over any load or transfer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (bus.flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)       s1_valid <= 1'b1;
            else if (s2_load) s1_valid <= 1'b0;

            if (s2_load)          s2_valid <= 1'b1;
            else if (bus.ready_i) s2_valid <= 1'b0;
        end
    end

    // Data registers only load on a stage advance, so they hold while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_az   <= '0;
            s1_lc   <= '0;
            s1_tag  <= '0;
            s2_res  <= '0;
            s2_zero <= 1'b0;
            s2_tag  <= '0;
        end else begin
            if (accept) begin
                s1_az  <= az_c;
                s1_lc  <= lc_c;
                s1_tag <= bus.tag_i;
            end
            if (s2_load) begin
                s2_res  <= res_c;
                s2_zero <= zero_c;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign bus.valid_o = s2_valid;
    assign bus.res_o   = s2_res;
    assign bus.zero_o  = s2_zero;
    assign bus.tag_o   = s2_tag;
endmodule

// File: tb/tb_mips_clz_pipe.sv
// tb/tb_mips_clz_pipe.sv - directed self-checking bench for mips_clz_pipe
module tb_mips_clz_pipe;
    logic clk;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    mips_clz_pipe_if #(.DATA_WIDTH(32), .DATA_WIDTH_LOG2(5), .TAG_WIDTH(4)) bus ();
    mips_clz_pipe_if #(.DATA_WIDTH(64), .DATA_WIDTH_LOG2(6), .TAG_WIDTH(4)) b64 ();
    mips_clz_pipe_if #(.DATA_WIDTH(16), .DATA_WIDTH_LOG2(4), .TAG_WIDTH(4)) b16 ();

    mips_clz_pipe #(.DATA_WIDTH(32), .DATA_WIDTH_LOG2(5), .GROUP_WIDTH(8), .TAG_WIDTH(4))
        u_dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
    mips_clz_pipe #(.DATA_WIDTH(64), .DATA_WIDTH_LOG2(6), .GROUP_WIDTH(8), .TAG_WIDTH(4))
        u_dut64 (.clk_i(clk), .rst_n_i(rst_n), .bus(b64));
    mips_clz_pipe #(.DATA_WIDTH(16), .DATA_WIDTH_LOG2(4), .GROUP_WIDTH(4), .TAG_WIDTH(4))
        u_dut16 (.clk_i(clk), .rst_n_i(rst_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference count for 32-bit operands.
    function automatic int ref_cnt(input logic op, input logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i] != op) return 31 - i;
        end
        return 32;
    endfunction

    // One isolated operation with ready_i=1: checks acceptance and 2-cycle latency.
    task automatic run_one(input string name, input logic op, input logic [31:0] d,
                           input logic [3:0] tg, input int exp_res, input logic exp_z);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.data_i  = d;
        bus.tag_i   = tg;
        #1;
        chk({name, "_rdy"}, 64'(bus.ready_o), 64'd1);
        tick();
        bus.valid_i = 1'b0;
        chk({name, "_lat1"}, 64'(bus.valid_o), 64'd0);
        tick();
        chk(name, 64'({bus.valid_o, bus.zero_o, bus.res_o, bus.tag_o}),
            64'({1'b1, exp_z, 6'(exp_res), tg}));
        tick();
    endtask

    logic [10:0] q[$];
    logic [10:0] exp_item;
    logic [31:0] d;
    logic        op;
    logic [9:0]  held;
    logic [63:0] w64;
    logic [15:0] w16;
    int          acc;
    int          cnt;

    initial begin
        rst_n = 1'b0;
        bus.flush_i = 0; bus.valid_i = 0; bus.op_i = 0; bus.data_i = '0; bus.tag_i = '0; bus.ready_i = 1;
        b64.flush_i = 0; b64.valid_i = 0; b64.op_i = 0; b64.data_i = '0; b64.tag_i = '0; b64.ready_i = 1;
        b16.flush_i = 0; b16.valid_i = 0; b16.op_i = 0; b16.data_i = '0; b16.tag_i = '0; b16.ready_i = 1;

        // Reset state
        #2;
        chk("rst_out", 64'({bus.valid_o, bus.res_o, bus.zero_o, bus.tag_o}), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 64'(bus.ready_o), 64'd1);
        tick();

        // Directed CLZ/CLO
        run_one("clz_8000",  1'b0, 32'h0000_8000, 4'h1, 16, 1'b0);
        run_one("clz_msb",   1'b0, 32'h8000_0000, 4'h2, 0,  1'b0);
        run_one("clz_lsb",   1'b0, 32'h0000_0001, 4'h3, 31, 1'b0);
        run_one("clz_zero",  1'b0, 32'h0000_0000, 4'h4, 32, 1'b1);
        run_one("clo_fff0",  1'b1, 32'hFFFF_FFF0, 4'h5, 28, 1'b0);
        run_one("clo_ones",  1'b1, 32'hFFFF_FFFF, 4'h6, 32, 1'b1);
        run_one("clo_7fff",  1'b1, 32'h7FFF_FFFF, 4'h7, 0,  1'b0);
        run_one("clo_fffe",  1'b1, 32'hFFFE_0000, 4'h8, 15, 1'b0);

        // Streaming: 100 operands back-to-back
        q.delete();
        for (int k = 0; k < 104; k++) begin
            if (k < 100) begin
                op = 1'($urandom_range(0, 1));
                d  = $urandom() >> $urandom_range(0, 32);
                if (op) d = ~d;
                bus.valid_i = 1'b1;
                bus.op_i    = op;
                bus.data_i  = d;
                bus.tag_i   = 4'(k);
                q.push_back({(ref_cnt(op, d) == 32), 6'(ref_cnt(op, d)), 4'(k)});
            end else begin
                bus.valid_i = 1'b0;
            end
            tick();
            chk("stream_valid", 64'(bus.valid_o), 64'((k >= 1 && k <= 100) ? 1 : 0));
            if (bus.valid_o && q.size() > 0) begin
                exp_item = q.pop_front();
                chk("stream_res", 64'({bus.zero_o, bus.res_o, bus.tag_o}), 64'(exp_item));
            end
        end
        chk("stream_left", 64'(q.size()), 64'd0);

        // Backpressure: ready_i=0 for 5 cycles with valid_i held
        bus.ready_i = 1'b0;
        acc = 0;
        held = '0;
        q.delete();
        for (int k = 0; k < 5; k++) begin
            d = 32'h1 << (acc * 3 + 5);
            bus.valid_i = 1'b1;
            bus.op_i    = 1'b0;
            bus.data_i  = d;
            bus.tag_i   = 4'(8 + acc);
            #1;
            if (bus.ready_o) begin
                q.push_back({1'b0, 6'(ref_cnt(1'b0, d)), 4'(8 + acc)});
                acc++;
            end
            tick();
            if (k == 1) held = {bus.res_o, bus.tag_o};
            if (k >= 2) chk("bp_stable", 64'({bus.res_o, bus.tag_o}), 64'(held));
        end
        chk("bp_acc", 64'(acc), 64'd2);
        chk("bp_rdy_low", 64'(bus.ready_o), 64'd0);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        #1;
        chk("bp_rdy_release", 64'(bus.ready_o), 64'd1);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.valid_o) begin
                cnt++;
                chk("bp_extra", 64'(q.size() != 0), 64'd1);
                if (q.size() > 0) begin
                    exp_item = q.pop_front();
                    chk("bp_drain", 64'({bus.zero_o, bus.res_o, bus.tag_o}), 64'(exp_item));
                end
            end
            tick();
        end
        chk("bp_count", 64'(cnt), 64'd2);

        // Flush with tags 1,2 in flight and tag 3 offered
        bus.valid_i = 1'b1; bus.op_i = 1'b0; bus.data_i = 32'h0000_0100; bus.tag_i = 4'h1;
        tick();
        bus.tag_i = 4'h2;
        tick();
        bus.tag_i = 4'h3;
        bus.flush_i = 1'b1;
        #1;
        chk("flush_rdy", 64'(bus.ready_o), 64'd0);
        tick();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_v0", 64'(bus.valid_o), 64'd0);
        tick();
        chk("flush_v1", 64'(bus.valid_o), 64'd0);
        tick();
        chk("flush_v2", 64'(bus.valid_o), 64'd0);
        run_one("flush_tag4", 1'b0, 32'h00F0_0000, 4'h4, 8, 1'b0);

        // Parameter sweep: 64-bit / 8-bit groups
        for (int p = 0; p <= 64; p++) begin
            w64 = (p < 64) ? (64'h1 << (63 - p)) : 64'h0;
            b64.valid_i = 1'b1; b64.op_i = 1'b0; b64.data_i = w64; b64.tag_i = 4'(p);
            tick();
            b64.valid_i = 1'b0;
            tick();
            chk("w64", 64'({b64.valid_o, b64.zero_o, b64.res_o, b64.tag_o}),
                64'({1'b1, (p == 64), 7'(p), 4'(p)}));
        end

        // Parameter sweep: 16-bit / 4-bit groups, both modes
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p <= 16; p++) begin
                w16 = (p < 16) ? (16'h1 << (15 - p)) : 16'h0;
                if (m == 1) w16 = ~w16;
                b16.valid_i = 1'b1; b16.op_i = 1'(m); b16.data_i = w16; b16.tag_i = 4'(p);
                tick();
                b16.valid_i = 1'b0;
                tick();
                chk("w16", 64'({b16.valid_o, b16.zero_o, b16.res_o, b16.tag_o}),
                    64'({1'b1, (p == 16), 5'(p), 4'(p)}));
            end
        end

        // Asynchronous reset mid-cycle with both stages full
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1; bus.op_i = 1'b0; bus.data_i = 32'h0000_0001; bus.tag_i = 4'h5;
        tick();
        bus.tag_i = 4'h6;
        tick();
        bus.valid_i = 1'b0;
        chk("rst_pre_full", 64'({bus.valid_o, bus.ready_o}), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({bus.valid_o, bus.res_o, bus.zero_o, bus.tag_o}), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        #1;
        chk("rst_rel_rdy", 64'(bus.ready_o), 64'd1);
        tick();
        chk("rst_discard0", 64'(bus.valid_o), 64'd0);
        tick();
        chk("rst_discard1", 64'(bus.valid_o), 64'd0);
        run_one("post_rst", 1'b1, 32'hC000_0000, 4'h9, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
